// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcode/funct
// constants, datapath mux/ALU encodings and the arithmetic funct decoder.
package mc_ctrl_pkg;

  typedef enum logic [4:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_WB_ALU,
    S_ADDR,
    S_MEM_RD,
    S_WB_MEM,
    S_MEM_WR,
    S_BRANCH,
    S_LUI,
    S_JAL,
    S_JALR,
    S_HALT,
    S_ILLEGAL,
    S_EXC
  } stateT;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  typedef enum logic [2:0] {
    ALU_PASSB = 3'd0,
    ALU_ADD   = 3'd1,
    ALU_SUB   = 3'd2,
    ALU_AND   = 3'd3,
    ALU_SLT   = 3'd4
  } aluOpT;

  typedef enum logic [1:0] {
    PC_ALU    = 2'd0,
    PC_ALUOUT = 2'd1,
    PC_EXC    = 2'd2
  } pcSrcT;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'd0,
    SRCA_A     = 2'd1,
    SRCA_PCOLD = 2'd2
  } srcAT;

  typedef enum logic [1:0] {
    SRCB_B    = 2'd0,
    SRCB_FOUR = 2'd1,
    SRCB_IMM  = 2'd2
  } srcBT;

  typedef enum logic [1:0] {
    WB_ALUOUT = 2'd0,
    WB_MDR    = 2'd1,
    WB_IMM    = 2'd2,
    WB_PC     = 2'd3
  } wbSelT;

  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd0;
  localparam logic [1:0] CAUSE_OVERFLOW = 2'd1;

  typedef struct packed {
    logic  legal;
    aluOpT op;
  } aluDecT;

  // R-type decodes funct7:funct3, I-type only funct3 (funct7 is immediate there).
  function automatic aluDecT decodeArith(input logic isR, input logic [6:0] f7,
                                         input logic [2:0] f3);
    aluDecT d;
    d.legal = 1'b1;
    d.op    = ALU_ADD;
    if (isR) begin
      case ({f7, f3})
        {F7_BASE, F3_ADD}: d.op = ALU_ADD;
        {F7_ALT,  F3_ADD}: d.op = ALU_SUB;
        {F7_BASE, F3_AND}: d.op = ALU_AND;
        {F7_BASE, F3_SLT}: d.op = ALU_SLT;
        default:           d.legal = 1'b0;
      endcase
    end else begin
      case (f3)
        F3_ADD:  d.op = ALU_ADD;
        F3_SLT:  d.op = ALU_SLT;
        default: d.legal = 1'b0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/mc_wait_counter.sv
// Memory wait counter: counts 0..MEM_LAT while enabled, done once MEM_LAT is reached.
module mc_wait_counter #(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic done
);

  logic [3:0] count;

  // Clear wins so every state entry starts a fresh wait from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !done) begin
      count <= count + 4'd1;
    end
  end

  assign done = (count == 4'(MEM_LAT));

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle control FSM for the RV64I-subset core. Define MC_CTRL_EXCEPTION_EN
// to send illegal instructions and add/sub overflow to the EXC trap state.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int XLEN    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        alu_lt,
  input  logic        alu_ovf,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        ir_load,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_addr_sel,
  output logic        a_load,
  output logic        b_load,
  output logic        aluout_load,
  output logic        mdr_load,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        epc_load,
  output logic [1:0]  cause,
  output logic        halted
);

  stateT      state;
  stateT      nextState;
  logic       waitDone;
  logic       waitEn;
  aluDecT     arith;
  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign arith  = decodeArith(opcode == OP_R, funct7, funct3);

`ifdef MC_CTRL_EXCEPTION_EN
  localparam stateT IllegalTarget = S_EXC;
  // Only a legal add/sub can overflow, so the trap cause is recoverable from IR alone.
  logic isAddSub;
  assign isAddSub = ((opcode == OP_R) || (opcode == OP_I)) && arith.legal &&
                    ((arith.op == ALU_ADD) || (arith.op == ALU_SUB));
  logic unusedBits;
  assign unusedBits = ^{instr[24:15], instr[11:7], XLEN[0]};
`else
  localparam stateT IllegalTarget = S_ILLEGAL;
  logic unusedBits;
  assign unusedBits = ^{instr[24:15], instr[11:7], XLEN[0], alu_ovf};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_RESET;
    end else begin
      state <= nextState;
    end
  end

  assign waitEn = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);

  mc_wait_counter #(.MEM_LAT(MEM_LAT)) uWait (
    .clk    (clk),
    .rst    (rst),
    .clear  (nextState != state),
    .enable (waitEn),
    .done   (waitDone)
  );

  // Next state and all strobes; everything defaults low so each state lists only what it raises.
  always_comb begin
    nextState    = state;
    pc_write     = 1'b0;
    pc_src       = PC_ALU;
    ir_load      = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr_sel = 1'b0;
    a_load       = 1'b0;
    b_load       = 1'b0;
    aluout_load  = 1'b0;
    mdr_load     = 1'b0;
    alu_src_a    = SRCA_PC;
    alu_src_b    = SRCB_B;
    alu_op       = ALU_PASSB;
    reg_write    = 1'b0;
    wb_sel       = WB_ALUOUT;
    epc_load     = 1'b0;
    cause        = CAUSE_ILLEGAL;
    halted       = 1'b0;

    case (state)
      S_RESET: nextState = S_FETCH;

      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALU_ADD;
        if (waitDone) begin
          ir_load   = 1'b1;
          pc_write  = 1'b1;
          nextState = S_DECODE;
        end
      end

      S_DECODE: begin
        a_load      = 1'b1;
        b_load      = 1'b1;
        aluout_load = 1'b1;
        alu_src_a   = SRCA_PCOLD;
        alu_src_b   = SRCB_IMM;
        alu_op      = ALU_ADD;
        case (opcode)
          OP_R:                nextState = S_EXEC_R;
          OP_I:                nextState = S_EXEC_I;
          OP_LOAD, OP_STORE:   nextState = S_ADDR;
          OP_BRANCH:           nextState = S_BRANCH;
          OP_LUI:              nextState = S_LUI;
          OP_JAL:              nextState = S_JAL;
          OP_JALR:             nextState = S_JALR;
          OP_SYSTEM:           nextState = S_HALT;
          default:             nextState = IllegalTarget;
        endcase
      end

      S_EXEC_R, S_EXEC_I: begin
        nextState = IllegalTarget;
        if (arith.legal) begin
          alu_src_a   = SRCA_A;
          alu_src_b   = (state == S_EXEC_R) ? SRCB_B : SRCB_IMM;
          alu_op      = arith.op;
          aluout_load = 1'b1;
          nextState   = S_WB_ALU;
`ifdef MC_CTRL_EXCEPTION_EN
          if (alu_ovf && isAddSub) begin
            nextState = S_EXC;
          end
`endif
        end
      end

      S_WB_ALU: begin
        reg_write = 1'b1;
        nextState = S_FETCH;
      end

      S_ADDR: begin
        alu_src_a   = SRCA_A;
        alu_src_b   = SRCB_IMM;
        alu_op      = ALU_ADD;
        aluout_load = 1'b1;
        nextState   = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        mem_read     = 1'b1;
        mem_addr_sel = 1'b1;
        if (waitDone) begin
          mdr_load  = 1'b1;
          nextState = S_WB_MEM;
        end
      end

      S_WB_MEM: begin
        reg_write = 1'b1;
        wb_sel    = WB_MDR;
        nextState = S_FETCH;
      end

      S_MEM_WR: begin
        mem_write    = 1'b1;
        mem_addr_sel = 1'b1;
        if (waitDone) begin
          nextState = S_FETCH;
        end
      end

      S_BRANCH: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_B;
        alu_op    = ALU_SUB;
        pc_src    = PC_ALUOUT;
        nextState = S_FETCH;
        case (funct3)
          F3_BEQ:  pc_write = alu_zero;
          F3_BNE:  pc_write = !alu_zero;
          F3_BLT:  pc_write = alu_lt;
          F3_BGE:  pc_write = !alu_lt;
          default: nextState = IllegalTarget;
        endcase
      end

      S_LUI: begin
        reg_write = 1'b1;
        wb_sel    = WB_IMM;
        nextState = S_FETCH;
      end

      S_JAL: begin
        reg_write = 1'b1;
        wb_sel    = WB_PC;
        pc_write  = 1'b1;
        pc_src    = PC_ALUOUT;
        nextState = S_FETCH;
      end

      S_JALR: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
        pc_write  = 1'b1;
        reg_write = 1'b1;
        wb_sel    = WB_PC;
        nextState = S_FETCH;
      end

      S_HALT: halted = 1'b1;

      S_ILLEGAL: nextState = S_FETCH;

`ifdef MC_CTRL_EXCEPTION_EN
      S_EXC: begin
        epc_load  = 1'b1;
        cause     = isAddSub ? CAUSE_OVERFLOW : CAUSE_ILLEGAL;
        pc_write  = 1'b1;
        pc_src    = PC_EXC;
        nextState = S_FETCH;
      end
`endif

      default: nextState = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Testbench for mc_control_unit: two instances (MEM_LAT 2 and 0) driven in turn,
// each checked cycle by cycle against a per-instruction expected-strobe sequence.
module tb_mc_control_unit;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_load;
    logic       mem_read;
    logic       mem_write;
    logic       mem_addr_sel;
    logic       a_load;
    logic       b_load;
    logic       aluout_load;
    logic       mdr_load;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       epc_load;
    logic [1:0] cause;
    logic       halted;
  } ctrlT;

  typedef ctrlT ctrlQT[$];

`ifdef MC_CTRL_EXCEPTION_EN
  localparam bit ExcEn = 1'b1;
`else
  localparam bit ExcEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        aluZero = 1'b0;
  logic        aluLt = 1'b0;
  logic        aluOvf = 1'b0;

  logic       pcWrite[2];
  logic [1:0] pcSrc[2];
  logic       irLoad[2];
  logic       memRead[2];
  logic       memWrite[2];
  logic       memAddrSel[2];
  logic       aLoad[2];
  logic       bLoad[2];
  logic       aluoutLoad[2];
  logic       mdrLoad[2];
  logic [1:0] aluSrcA[2];
  logic [1:0] aluSrcB[2];
  logic [2:0] aluOp[2];
  logic       regWrite[2];
  logic [1:0] wbSel[2];
  logic       epcLoad[2];
  logic [1:0] cause[2];
  logic       halted[2];

  int   sel = 0;
  int   curL = 2;
  ctrlT expQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gDut
    mc_control_unit #(.MEM_LAT((g == 0) ? 2 : 0), .XLEN(64)) dut (
      .clk          (clk),
      .rst          (rst),
      .instr        (instr),
      .alu_zero     (aluZero),
      .alu_lt       (aluLt),
      .alu_ovf      (aluOvf),
      .pc_write     (pcWrite[g]),
      .pc_src       (pcSrc[g]),
      .ir_load      (irLoad[g]),
      .mem_read     (memRead[g]),
      .mem_write    (memWrite[g]),
      .mem_addr_sel (memAddrSel[g]),
      .a_load       (aLoad[g]),
      .b_load       (bLoad[g]),
      .aluout_load  (aluoutLoad[g]),
      .mdr_load     (mdrLoad[g]),
      .alu_src_a    (aluSrcA[g]),
      .alu_src_b    (aluSrcB[g]),
      .alu_op       (aluOp[g]),
      .reg_write    (regWrite[g]),
      .wb_sel       (wbSel[g]),
      .epc_load     (epcLoad[g]),
      .cause        (cause[g]),
      .halted       (halted[g])
    );
  end

  function automatic ctrlT actual(input int k);
    ctrlT c;
    c.pc_write     = pcWrite[k];
    c.pc_src       = pcSrc[k];
    c.ir_load      = irLoad[k];
    c.mem_read     = memRead[k];
    c.mem_write    = memWrite[k];
    c.mem_addr_sel = memAddrSel[k];
    c.a_load       = aLoad[k];
    c.b_load       = bLoad[k];
    c.aluout_load  = aluoutLoad[k];
    c.mdr_load     = mdrLoad[k];
    c.alu_src_a    = aluSrcA[k];
    c.alu_src_b    = aluSrcB[k];
    c.alu_op       = aluOp[k];
    c.reg_write    = regWrite[k];
    c.wb_sel       = wbSel[k];
    c.epc_load     = epcLoad[k];
    c.cause        = cause[k];
    c.halted       = halted[k];
    return c;
  endfunction

  function automatic ctrlT excCycle(input logic [1:0] why);
    ctrlT c = '0;
    c.epc_load = 1'b1;
    c.cause    = why;
    c.pc_write = 1'b1;
    c.pc_src   = 2'd2;
    return c;
  endfunction

  // Expected strobes for one instruction, cycle by cycle, from fetch to its return to fetch.
  function automatic ctrlQT modelSeq(input logic [31:0] ins, input logic z, input logic l,
                                     input logic o, input int lat);
    ctrlQT      s;
    ctrlT       c;
    logic [6:0] opc = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    logic [6:0] f7 = ins[31:25];
    int         op = 0;
    bit         legal = 1'b1;
    bit         illegal = 1'b0;
    for (int i = 0; i <= lat; i++) begin
      c = '0;
      c.mem_read = 1'b1; c.alu_src_b = 2'd1; c.alu_op = 3'd1;
      if (i == lat) begin c.ir_load = 1'b1; c.pc_write = 1'b1; end
      s.push_back(c);
    end
    c = '0;
    c.a_load = 1'b1; c.b_load = 1'b1; c.aluout_load = 1'b1;
    c.alu_src_a = 2'd2; c.alu_src_b = 2'd2; c.alu_op = 3'd1;
    s.push_back(c);
    case (opc)
      7'h33, 7'h13: begin
        if (opc == 7'h33) begin
          if (f7 == 7'h00 && f3 == 3'd0) op = 1;
          else if (f7 == 7'h20 && f3 == 3'd0) op = 2;
          else if (f7 == 7'h00 && f3 == 3'd7) op = 3;
          else if (f7 == 7'h00 && f3 == 3'd2) op = 4;
          else legal = 1'b0;
        end else begin
          if (f3 == 3'd0) op = 1;
          else if (f3 == 3'd2) op = 4;
          else legal = 1'b0;
        end
        c = '0;
        if (legal) begin
          c.alu_src_a = 2'd1; c.alu_src_b = (opc == 7'h33) ? 2'd0 : 2'd2;
          c.alu_op = 3'(op); c.aluout_load = 1'b1;
          s.push_back(c);
          if (ExcEn && o && (op == 1 || op == 2)) begin
            s.push_back(excCycle(2'd1));
          end else begin
            c = '0; c.reg_write = 1'b1;
            s.push_back(c);
          end
        end else begin
          s.push_back(c);
          illegal = 1'b1;
        end
      end
      7'h03, 7'h23: begin
        c = '0;
        c.alu_src_a = 2'd1; c.alu_src_b = 2'd2; c.alu_op = 3'd1; c.aluout_load = 1'b1;
        s.push_back(c);
        for (int i = 0; i <= lat; i++) begin
          c = '0;
          c.mem_addr_sel = 1'b1;
          if (opc == 7'h03) begin
            c.mem_read = 1'b1;
            c.mdr_load = (i == lat);
          end else begin
            c.mem_write = 1'b1;
          end
          s.push_back(c);
        end
        if (opc == 7'h03) begin
          c = '0; c.reg_write = 1'b1; c.wb_sel = 2'd1;
          s.push_back(c);
        end
      end
      7'h63: begin
        c = '0;
        c.alu_src_a = 2'd1; c.alu_op = 3'd2; c.pc_src = 2'd1;
        case (f3)
          3'd0: c.pc_write = z;
          3'd1: c.pc_write = !z;
          3'd4: c.pc_write = l;
          3'd5: c.pc_write = !l;
          default: illegal = 1'b1;
        endcase
        s.push_back(c);
      end
      7'h37: begin c = '0; c.reg_write = 1'b1; c.wb_sel = 2'd2; s.push_back(c); end
      7'h6F: begin
        c = '0; c.reg_write = 1'b1; c.wb_sel = 2'd3; c.pc_write = 1'b1; c.pc_src = 2'd1;
        s.push_back(c);
      end
      7'h67: begin
        c = '0; c.alu_src_a = 2'd1; c.alu_src_b = 2'd2; c.alu_op = 3'd1;
        c.pc_write = 1'b1; c.reg_write = 1'b1; c.wb_sel = 2'd3;
        s.push_back(c);
      end
      7'h73: begin
        for (int i = 0; i < 20; i++) begin c = '0; c.halted = 1'b1; s.push_back(c); end
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) s.push_back(ExcEn ? excCycle(2'd0) : ctrlT'('0));
    return s;
  endfunction

  task automatic checkOutput(input string name, input ctrlT got, input ctrlT want);
    testsRun++;
    if (got !== want) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic checkValue(input string name, input int got, input int want);
    testsRun++;
    if (got != want) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    ctrlT e;
    if (!rst && expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput($sformatf("L=%0d instr %h", curL, instr), actual(sel), e);
    end
  end

  task automatic waitDrain(input string name);
    int budget = 0;
    while (expQ.size() > 0 && budget < 200) begin
      @(posedge clk);
      budget++;
    end
    if (expQ.size() > 0) begin
      checkValue({name, " drain timeout"}, expQ.size(), 0);
      expQ.delete();
    end
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] ins, input logic z, input logic l,
                               input logic o);
    ctrlQT s;
    instr = ins; aluZero = z; aluLt = l; aluOvf = o;
    s = modelSeq(ins, z, l, o, curL);
    foreach (s[i]) expQ.push_back(s[i]);
    waitDrain("instr");
  endtask

  task automatic doReset();
    @(posedge clk);
    #2 rst = 1'b1;
    expQ.delete();
    #1 checkOutput("outputs in reset", actual(sel), '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    expQ.push_back('0);
  endtask

  function automatic logic [31:0] randInstr();
    logic [31:0] ins = $urandom;
    logic [6:0]  op;
    case ($urandom_range(0, 9))
      0: begin
        ins[6:0] = 7'h33;
        ins[31:25] = ($urandom_range(0, 2) == 0) ? 7'h20 : (($urandom_range(0, 3) == 0) ? 7'h01 : 7'h00);
        if ($urandom_range(0, 1) == 1) ins[14:12] = ($urandom_range(0, 1) == 1) ? 3'd7 : 3'd2;
      end
      1: ins[6:0] = 7'h13;
      2: ins[6:0] = 7'h03;
      3: ins[6:0] = 7'h23;
      4: ins[6:0] = 7'h63;
      5: ins[6:0] = 7'h37;
      6: ins[6:0] = 7'h6F;
      7: ins[6:0] = 7'h67;
      8: begin
        do op = 7'($urandom_range(0, 127));
        while (op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h67, 7'h73});
        ins[6:0] = op;
      end
      default: begin
        ins[6:0] = 7'h33; ins[14:12] = 3'd0;
        ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      end
    endcase
    return ins;
  endfunction

  task automatic resetMidLoad();
    ctrlQT s;
    int    budget = 0;
    instr = 32'h0000B183; aluZero = 1'b0; aluLt = 1'b0; aluOvf = 1'b0;
    s = modelSeq(instr, 1'b0, 1'b0, 1'b0, curL);
    foreach (s[i]) expQ.push_back(s[i]);
    while (expQ.size() > 3 && budget < 100) begin
      @(posedge clk);
      budget++;
    end
    checkValue("reached mem wait", expQ.size(), 3);
    #2 rst = 1'b1;
    #1 checkOutput("outputs on mid-wait reset", actual(sel), '0);
    expQ.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    expQ.push_back('0);
  endtask

  task automatic pinModel();
    ctrlQT s;
    int    irCount = 0;
    s = modelSeq(32'h002081B3, 1'b0, 1'b0, 1'b0, 2);
    checkValue("model add L2 length", s.size(), 6);
    checkValue("model add L2 wb cycle6", int'(s[5].reg_write), 1);
    foreach (s[i]) irCount += int'(s[i].ir_load);
    checkValue("model add L2 ir_load count", irCount, 1);
    checkValue("model add L2 ir_load cycle3", int'(s[2].ir_load), 1);
    s = modelSeq(32'h0000B183, 1'b0, 1'b0, 1'b0, 0);
    checkValue("model ld L0 length", s.size(), 5);
    checkValue("model ld L0 mdr_load", int'(s[3].mdr_load), 1);
    checkValue("model ld L0 wb_sel", int'(s[4].wb_sel), 1);
    s = modelSeq(32'h00208463, 1'b1, 1'b0, 1'b0, 2);
    checkValue("model beq L2 length", s.size(), 5);
    checkValue("model beq taken pc_write", int'(s[4].pc_write), 1);
  endtask

  initial begin
    pinModel();

    sel = 0; curL = 2;
    doReset();
    applyStimulus(32'h002081B3, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h00208463, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h00208463, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h0020C463, 1'b0, 1'b1, 1'b0);
    applyStimulus(32'h0020D463, 1'b0, 1'b1, 1'b0);
    applyStimulus(32'h0000B183, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h0030B023, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h123451B7, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h008000EF, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h00008067, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h0000007F, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h402081B3, 1'b0, 1'b0, 1'b1);
    applyStimulus(32'h0020E1B3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 120; i++) begin
      applyStimulus(randInstr(), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    resetMidLoad();
    applyStimulus(32'h002081B3, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h00100073, 1'b0, 1'b0, 1'b0);

    sel = 1; curL = 0;
    doReset();
    applyStimulus(32'h0000B183, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h0000007F, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h0030B023, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 120; i++) begin
      applyStimulus(randInstr(), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    applyStimulus(32'h00100073, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Parametrised multicycle control unit for the RV64I-subset processor. Successor to the current hard-wired multicycle controller: adds configurable memory latency with an internal wait counter, more instruction classes (and/slt/slti, blt/bge, jal/jalr, ebreak), explicit defaults for every output in every state, and optional exception sequencing. Sits between the instruction register / ALU flags and all datapath load, mux and memory strobes.

## Interface
- MEM_LAT, 1: memory wait cycles per access, legal range 0..15
- XLEN, 64: datapath width; only used for the flag semantics noted below
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- instr  in  32  current IR contents
- alu_zero  in  1  ALU result == 0
- alu_lt  in  1  signed A < B (XLEN-bit compare)
- alu_ovf  in  1  signed overflow of the XLEN-bit add/sub
- pc_write  out  1  load PC
- pc_src  out  2  0 ALU result, 1 ALUOut, 2 exception vector
- ir_load  out  1  load IR (also loads PC_old)
- mem_read, mem_write  out  1 each
- mem_addr_sel  out  1  0 PC, 1 ALUOut
- a_load, b_load, aluout_load, mdr_load  out  1 each
- alu_src_a  out  2  0 PC, 1 A, 2 PC_old
- alu_src_b  out  2  0 B, 1 const 4, 2 immediate
- alu_op  out  3  0 pass-B, 1 ADD, 2 SUB, 3 AND, 4 SLT
- reg_write  out  1
- wb_sel  out  2  0 ALUOut, 1 MDR, 2 immediate (lui), 3 PC (link)
- epc_load  out  1; cause  out  2 (0 illegal, 1 overflow)
- halted  out  1  high in HALT

## Operation
- Every output defaults to 0 in every state; only listed strobes are raised. No latches.
- RESET: all 0; next FETCH.
- FETCH: mem_read=1, mem_addr_sel=0, alu_src_a=0, alu_src_b=1, alu_op=ADD for MEM_LAT+1 cycles; ir_load and pc_write (pc_src=0) only in the final cycle; next DECODE.
- DECODE: a_load, b_load, aluout_load; ALU computes PC_old+imm (src_a=2, src_b=2, ADD). Dispatch on instr[6:0]: 0x33 EXEC_R, 0x13 EXEC_I, 0x03/0x23 ADDR, 0x63 BRANCH, 0x37 LUI, 0x6F JAL, 0x67 JALR, 0x73 HALT, else ILLEGAL.
- EXEC_R: src A/B; funct7:funct3 0x00:000 ADD, 0x20:000 SUB, 0x00:111 AND, 0x00:010 SLT, else ILLEGAL; aluout_load; next WB_ALU. EXEC_I: src A/imm; funct3 000 ADD, 010 SLT, else ILLEGAL.
- WB_ALU: reg_write, wb_sel=0; next FETCH.
- ADDR: A+imm, aluout_load; load to MEM_RD, store to MEM_WR.
- MEM_RD: mem_read, mem_addr_sel=1 for MEM_LAT+1 cycles, mdr_load in final cycle; next WB_MEM (reg_write, wb_sel=1). MEM_WR: mem_write held MEM_LAT+1 cycles; next FETCH.
- BRANCH: src A/B, SUB; taken = funct3 000 zero, 001 !zero, 100 lt, 101 !lt; pc_write=taken, pc_src=1; other funct3 ILLEGAL. Next FETCH.
- LUI: reg_write, wb_sel=2. JAL: reg_write, wb_sel=3, pc_write, pc_src=1. JALR: A+imm, pc_src=0, pc_write, reg_write, wb_sel=3. All next FETCH.
- HALT: halted=1, absorbing until rst.

## Timing
- State registered; outputs combinational from state, IR and flags (BRANCH and overflow checks are Mealy).
- Instruction cycles (L=MEM_LAT): R/I L+4, load 2L+5, store 2L+4, branch/lui/jal/jalr L+3.
- Wait counter clears on every state entry; counts 0..L; done when count==L. L=0 gives single-cycle accesses.
- Async rst at any point, including mid-wait: state RESET, counter 0, all outputs 0 immediately; first FETCH on the first clk edge after release.

## Configuration
- MC_CTRL_EXCEPTION_EN defined: ILLEGAL and overflow (alu_ovf in EXEC_R/EXEC_I ADD/SUB, checked in that cycle, next state EXC instead of WB_ALU) go to EXC: epc_load, cause set, pc_write, pc_src=2, no reg_write; next FETCH.
- Undefined: ILLEGAL behaves as a 1-cycle no-op back to FETCH; alu_ovf ignored; epc_load and cause tied 0.

## Structure
- Package mc_ctrl_pkg: state enum, opcode/funct constants, alu_op, pc_src, alu_src, wb_sel encodings.
- Sub-module mc_wait_counter (clear, enable, MEM_LAT param, done output).

## Test plan
- Reset, MEM_LAT=2, add x3,x1,x2 (0x002081B3) -> FETCH 3 cycles, ir_load once, WB reg_write in cycle 6.
- beq with alu_zero=1 then 0 -> pc_write=1/pc_src=1, then pc_write=0; blt with alu_lt=1 -> taken.
- ld (0x0000B183), MEM_LAT=0 -> 5 cycles, mdr_load then reg_write with wb_sel=1.
- Opcode 0x7F with MC_CTRL_EXCEPTION_EN -> EXC, epc_load=1, cause=0, pc_src=2; without -> FETCH next cycle, no strobes.
- rst pulsed during MEM_RD wait -> outputs 0 same cycle, FETCH after release.
- ebreak (0x00100073) -> halted=1 held for 20 cycles, no strobes.
